ofm_packer: RTL

Write-back stage directly upstream of the output feature-map memory. Accepts the convolution datapath's 8-bit output pixels one per handshake, packs four into a 32-bit word (lane 0 = first byte = stored bits 31:24), and issues single-cycle writes at sequential word addresses. When the layer's last byte has been written it raises `done`, which the memory uses to trigger its file dump.

---
 rtl/ofm_packer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ofm_packer.sv
`timescale 1ns/1ps
// ofm_packer: write-back stage in front of the output feature-map memory.
// Packs accepted 8-bit pixels four per 32-bit word (lane 0 = bits 31:24),
// writes words at sequential addresses and raises `done` after the final
// byte of a layer has been written.
// Optional build macro: OFM_RELU_EN -- when defined, negative pixels
// (bit 7 set) are clamped to 8'h00 before packing; PAD is never clamped.
module ofm_packer #(
  parameter int          DEPTH = 128,
  parameter logic [7:0]  PAD   = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        wr,
  output logic [31:0] address,
  output logic [7:0]  wrData [0:3],
  output logic        done,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // The pointer must be able to hold DEPTH itself: that value means "full".
  localparam int             PW       = $clog2(DEPTH + 1);
  localparam logic [PW-1:0]  PTR_FULL = PW'(DEPTH);

  state_t         state_q, state_d;
  logic [PW-1:0]  ptr_q;
  logic [1:0]     lane_idx_q;
  logic [7:0]     lanes_q [0:3];
  logic [7:0]     lanes_d [0:3];
  logic           last_q;

  logic [7:0]     pix;
  logic           accept;
  logic           entering_write;
  logic           full;

  logic           in_ready_d, wr_d, done_d, overflow_d;
  logic [31:0]    address_d;
  logic [7:0]     wrData_d [0:3];

`ifdef OFM_RELU_EN
  // Signed pixel: clamp negatives to zero before they enter a lane.
  assign pix = in_data[7] ? 8'h00 : in_data;
`else
  assign pix = in_data;
`endif

  // A start pulse wins over a simultaneous handshake, so the byte is dropped.
  assign accept         = in_ready && in_valid && !start;
  assign entering_write = (state_d == WRITE);
  assign full           = (ptr_q == PTR_FULL);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start restarts the layer from any state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and a latch cannot be inferred.
    state_d = state_q;
    if (start) begin
      state_d = FILL;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        FILL:    if (accept && (lane_idx_q == 2'd3 || in_last)) state_d = WRITE;
        WRITE:   state_d = last_q ? FINISH : FILL;
        FINISH:  state_d = FINISH;
        default: state_d = IDLE;
      endcase
    end
  end

  // Lane contents including the byte accepted this cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) lanes_d[i] = lanes_q[i];
    if (accept) lanes_d[lane_idx_q] = pix;
  end

  // Next values of the registered outputs, derived from the next state.
  always_comb begin
    in_ready_d = (state_d == FILL);
    done_d     = (state_d == FINISH);
    wr_d       = entering_write && !full;
    overflow_d = start ? 1'b0 : (overflow || (entering_write && full));
    address_d  = address;
    for (int i = 0; i < 4; i++) wrData_d[i] = wrData[i];
    // Address and data only move on a real write; otherwise they hold.
    if (wr_d) begin
      address_d = 32'(ptr_q);
      for (int i = 0; i < 4; i++) wrData_d[i] = lanes_d[i];
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready <= 1'b0;
      wr       <= 1'b0;
      address  <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < 4; i++) wrData[i] <= 8'h00;
    end else begin
      in_ready <= in_ready_d;
      wr       <= wr_d;
      address  <= address_d;
      done     <= done_d;
      overflow <= overflow_d;
      for (int i = 0; i < 4; i++) wrData[i] <= wrData_d[i];
    end
  end

  // Packing datapath: pointer, lane index, lanes and the latched last flag.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      ptr_q      <= '0;
      lane_idx_q <= 2'd0;
      last_q     <= 1'b0;
      // NOTE: the four lanes are a small register array, not a RAM, so they
      // are reset explicitly; unfilled lanes of a partial word must read PAD.
      for (int i = 0; i < 4; i++) lanes_q[i] <= PAD;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            lanes_q    <= lanes_d;
            lane_idx_q <= lane_idx_q + 2'd1;
            last_q     <= in_last;
          end
        end
        WRITE: begin
          // A dropped (full) write leaves the pointer parked at DEPTH.
          if (wr) ptr_q <= ptr_q + PW'(1);
          lane_idx_q <= 2'd0;
          last_q     <= 1'b0;
          for (int i = 0; i < 4; i++) lanes_q[i] <= PAD;
        end
        default: ;
      endcase
    end
  end

endmodule
